// File: rtl/weight_buffer_mb.sv
// Multi-bank weight buffer: the host fills one bank with wide words while the
// PE side drains another bank as narrow lanes. Banks circulate in a ring and are
// handed over with write_done / read_done. Reads have a fixed 3-cycle latency.
module weight_buffer_mb #(
   parameter int RD_WIDTH      = 16,
   parameter int WR_WIDTH      = 64,
   parameter int WR_ADDR_WIDTH = 5,
   parameter int RD_ADDR_WIDTH = 7,
   parameter int NUM_BANKS     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write_req,
   input  logic [WR_ADDR_WIDTH-1:0]     write_addr,
   input  logic [WR_WIDTH-1:0]          write_data,
   input  logic                         write_done,
   output logic                         write_ready,
   input  logic                         read_req,
   input  logic [RD_ADDR_WIDTH-1:0]     read_addr,
   input  logic                         read_done,
   output logic                         read_ready,
   output logic [RD_WIDTH-1:0]          read_data,
   output logic                         read_data_valid,
   output logic [$clog2(NUM_BANKS):0]   bank_count
);

   localparam int DEPTH   = 1 << WR_ADDR_WIDTH;
   localparam int BANK_W  = $clog2(NUM_BANKS);
   localparam int CNT_W   = BANK_W + 1;
   localparam int RATIO   = WR_WIDTH / RD_WIDTH;
   localparam int LANE_W  = $clog2(RATIO);
   localparam int LANE_IW = (LANE_W > 0) ? LANE_W : 1;
   localparam int MEM_AW  = BANK_W + WR_ADDR_WIDTH;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BANKS);

   // Reject parameter sets where the lane split or the bank ring is ill-formed.
   if ((WR_WIDTH % RD_WIDTH) != 0 || (RATIO & (RATIO - 1)) != 0 ||
       RD_ADDR_WIDTH != WR_ADDR_WIDTH + LANE_W) begin : g_bad_width
      $error("weight_buffer_mb: WR_WIDTH/RD_WIDTH must be a power of 2 and RD_ADDR_WIDTH must match");
   end
   if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
      $error("weight_buffer_mb: NUM_BANKS must be a power of 2 and at least 2");
   end

   // Flattened storage: {bank, word} forms the address.
   logic [WR_WIDTH-1:0] mem [0:NUM_BANKS*DEPTH-1];

   logic [BANK_W-1:0] wr_ptr;
   logic [BANK_W-1:0] rd_ptr;

   logic wr_fire;
   logic rd_fire;
   logic wr_accept;
   logic rd_accept;

   // Read pipeline registers.
   logic                     s1_valid;
   logic [BANK_W-1:0]        s1_bank;
   logic [RD_ADDR_WIDTH-1:0] s1_addr;
   logic                     s2_valid;
   logic [WR_WIDTH-1:0]      s2_word;
   logic [LANE_IW-1:0]       s2_lane;

   logic [WR_ADDR_WIDTH-1:0] s1_word;
   logic [LANE_IW-1:0]       s1_lane;

   assign write_ready = (bank_count != FULL);
   assign read_ready  = (bank_count != '0);

   assign wr_accept = write_req  & write_ready;
   assign rd_accept = read_req   & read_ready;
   assign wr_fire   = write_done & write_ready;
   assign rd_fire   = read_done  & read_ready;

   assign s1_word = s1_addr[RD_ADDR_WIDTH-1 -: WR_ADDR_WIDTH];
   assign s1_lane = (LANE_W > 0) ? LANE_IW'(s1_addr) : '0;

   // Bank ring bookkeeping: pointers advance on accepted handovers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         bank_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (wr_fire) wr_ptr <= wr_ptr + BANK_W'(1);
         if (rd_fire) rd_ptr <= rd_ptr + BANK_W'(1);
         case ({wr_fire, rd_fire})
            2'b10:   bank_count <= bank_count + CNT_W'(1);
            2'b01:   bank_count <= bank_count - CNT_W'(1);
            default: bank_count <= bank_count;
         endcase
      end
   end

   // Wide write port into the current fill bank.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; contents are only meaningful once written,
      // and leaving it unreset lets it map onto plain RAM.
      if (wr_accept) mem[{wr_ptr, write_addr}] <= write_data;
   end

   // Three-stage read: capture address, read wide word (read-first), pick lane.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid        <= 1'b0;
         s2_valid        <= 1'b0;
         read_data_valid <= 1'b0;
         read_data       <= '0;
      end else begin
         s1_valid        <= rd_accept;
         s2_valid        <= s1_valid;
         read_data_valid <= s2_valid;
         if (rd_accept) begin
            s1_bank <= rd_ptr;
            s1_addr <= read_addr;
         end
         if (s1_valid) begin
            s2_word <= mem[MEM_AW'({s1_bank, s1_word})];
            s2_lane <= s1_lane;
         end
         if (s2_valid) read_data <= s2_word[s2_lane*RD_WIDTH +: RD_WIDTH];
      end
   end

endmodule

// File: tb/tb_weight_buffer_mb.sv
// Testbench for weight_buffer_mb: directed scenarios followed by random
// traffic, every cycle compared against a bank-level behavioural model.
module tb_weight_buffer_mb;

   localparam int RDW = 16;
   localparam int WRW = 64;
   localparam int WAW = 5;
   localparam int RAW = 7;
   localparam int NB  = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           write_req = 1'b0;
   logic [WAW-1:0] write_addr = '0;
   logic [WRW-1:0] write_data = '0;
   logic           write_done = 1'b0;
   logic           write_ready;
   logic           read_req = 1'b0;
   logic [RAW-1:0] read_addr = '0;
   logic           read_done = 1'b0;
   logic           read_ready;
   logic [RDW-1:0] read_data;
   logic           read_data_valid;
   logic [1:0]     bank_count;

   weight_buffer_mb #(
      .RD_WIDTH(RDW), .WR_WIDTH(WRW), .WR_ADDR_WIDTH(WAW),
      .RD_ADDR_WIDTH(RAW), .NUM_BANKS(NB)
   ) dut (
      .clk(clk), .reset(reset),
      .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
      .write_done(write_done), .write_ready(write_ready),
      .read_req(read_req), .read_addr(read_addr), .read_done(read_done),
      .read_ready(read_ready), .read_data(read_data),
      .read_data_valid(read_data_valid), .bank_count(bank_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Behavioural model: banks as a 2-D array, results as a timed queue.
   typedef struct {
      int             due;
      logic [RDW-1:0] d;
   } rd_t;

   logic [WRW-1:0] m_mem [NB][32];
   int             m_wp = 0;
   int             m_rp = 0;
   int             m_cnt = 0;
   logic [RDW-1:0] m_last = '0;
   int             cyc = 0;
   rd_t            m_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply the rules of one clock edge to the model, using pre-edge state.
   task automatic model_edge();
      logic           wr_ok;
      logic           rd_ok;
      logic [WRW-1:0] w;
      rd_t            e;
      cyc++;
      if (reset) begin
         m_wp = 0; m_rp = 0; m_cnt = 0; m_last = '0;
         m_q.delete();
      end else begin
         wr_ok = (m_cnt != NB);
         rd_ok = (m_cnt != 0);
         if (read_req && rd_ok) begin
            w     = m_mem[m_rp][read_addr / 4];
            e.due = cyc + 2;
            e.d   = w[(read_addr % 4) * RDW +: RDW];
            m_q.push_back(e);
         end
         if (write_req && wr_ok) m_mem[m_wp][write_addr] = write_data;
         if (write_done && wr_ok) begin m_wp = (m_wp + 1) % NB; m_cnt++; end
         if (read_done && rd_ok)  begin m_rp = (m_rp + 1) % NB; m_cnt--; end
      end
   endtask

   task automatic check_all();
      logic exp_v;
      exp_v = (m_q.size() > 0 && m_q[0].due == cyc);
      if (exp_v) begin
         m_last = m_q[0].d;
         void'(m_q.pop_front());
      end
      check("read_data_valid", read_data_valid, exp_v);
      check("read_data", read_data, m_last);
      check("bank_count", bank_count, m_cnt);
      check("write_ready", write_ready, m_cnt != NB);
      check("read_ready", read_ready, m_cnt != 0);
   endtask

   // One clock: model update at the edge, compare at the falling edge, then idle inputs.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      reset = 1'b0; write_req = 1'b0; write_done = 1'b0;
      read_req = 1'b0; read_done = 1'b0;
   endtask

   initial begin
      // Reset
      reset = 1'b1; tick();
      reset = 1'b1; tick();

      // Lane read-back
      write_req = 1'b1; write_addr = 5'd3; write_data = 64'h0004_0003_0002_0001; tick();
      write_done = 1'b1; tick();
      check("lane_count", bank_count, 64'd1);
      check("lane_read_ready", read_ready, 64'd1);
      for (int i = 12; i < 16; i++) begin
         read_req = 1'b1; read_addr = RAW'(i); tick();
      end
      tick(); tick(); tick();
      check("lane_last", read_data, 64'h0004);

      // Full / back-pressure (same-cycle write lands in the old fill bank)
      write_req = 1'b1; write_addr = 5'd3; write_data = 64'h0008_0007_0006_0005;
      write_done = 1'b1; tick();
      check("full_write_ready", write_ready, 64'd0);
      check("full_count", bank_count, 64'd2);
      write_req = 1'b1; write_addr = 5'd3; write_data = '1; tick();
      write_done = 1'b1; tick();
      check("full_count_after", bank_count, 64'd2);
      read_req = 1'b1; read_addr = 7'd12; tick(); tick(); tick();
      check("full_read12", read_data, 64'h0001);

      // Simultaneous handover at bank_count=1
      read_done = 1'b1; tick();
      write_req = 1'b1; write_addr = 5'd3; write_data = 64'h000C_000B_000A_0009;
      write_done = 1'b1; read_done = 1'b1; tick();
      check("simul_count", bank_count, 64'd1);
      read_req = 1'b1; read_addr = 7'd12; tick(); tick(); tick();
      check("simul_read", read_data, 64'h0009);

      // Read-first hazard: fill to full, then release a bank mid-read and overwrite it
      write_req = 1'b1; write_addr = 5'd3; write_data = 64'h0013_0012_0011_0010;
      write_done = 1'b1; tick();
      read_req = 1'b1; read_addr = 7'd12; read_done = 1'b1; tick();
      write_req = 1'b1; write_addr = 5'd3; write_data = 64'hAAAA_AAAA_AAAA_AAAA; tick();
      tick();
      check("hazard_read", read_data, 64'h0009);

      // Empty: reads and read_done at bank_count=0 are ignored
      read_done = 1'b1; tick();
      check("empty_count", bank_count, 64'd0);
      read_req = 1'b1; read_addr = 7'd12; tick(); tick(); tick();
      check("empty_hold", read_data, 64'h0009);
      read_done = 1'b1; tick();
      write_done = 1'b1; tick();
      read_req = 1'b1; read_addr = 7'd12; tick(); tick(); tick();
      check("empty_rdptr", read_data, 64'hAAAA);

      // Reset mid-read
      read_req = 1'b1; read_addr = 7'd13; tick();
      reset = 1'b1; tick();
      tick(); tick(); tick();
      check("rst_data", read_data, 64'd0);
      check("rst_count", bank_count, 64'd0);
      check("rst_write_ready", write_ready, 64'd1);

      // Random traffic on fully initialised banks
      for (int b = 0; b < NB; b++) begin
         for (int a = 0; a < 32; a++) begin
            write_req = 1'b1; write_addr = WAW'(a);
            write_data = {$urandom, $urandom};
            write_done = (a == 31);
            tick();
         end
      end
      for (int n = 0; n < 400; n++) begin
         write_req  = ($urandom % 2) == 0;
         write_addr = WAW'($urandom);
         write_data = {$urandom, $urandom};
         write_done = ($urandom % 10) == 0;
         read_req   = ($urandom % 4) != 0;
         read_addr  = RAW'($urandom);
         read_done  = ($urandom % 10) == 0;
         tick();
      end
      tick(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
